// File: rtl/compare_1b.sv
// Registered 1-bit equality/magnitude comparator with a saturating
// match counter and a sticky mismatch flag.
module compare_1b #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  output logic             y,
  output logic             gt,
  output logic             lt,
  output logic             out_valid,
  output logic [CNT_W-1:0] match_cnt,
  output logic             mismatch_seen
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             eq;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_nxt;

  assign eq      = ~(a ^ b);
  assign cnt_sat = (match_cnt == CNT_MAX);

  always_comb begin
    cnt_nxt = match_cnt;
    if (eq && !cnt_sat) begin
      cnt_nxt = match_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y             <= 1'b0;
      gt            <= 1'b0;
      lt            <= 1'b0;
      out_valid     <= 1'b0;
      match_cnt     <= '0;
      mismatch_seen <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) begin
        y         <= eq;
        gt        <= a & ~b;
        lt        <= ~a & b;
        match_cnt <= cnt_nxt;
        if (!eq) begin
          mismatch_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_compare_1b.sv
// Self-checking bench for compare_1b: directed plan plus random run
// against a behavioural model; CNT_W=8 and CNT_W=2 instances in parallel.
module tb_compare_1b;

  logic       clk = 1'b0;
  logic       rst, en, a, b;
  logic       y, gt, lt, out_valid, mismatch_seen;
  logic [7:0] match_cnt;
  logic       y2, gt2, lt2, ov2, ms2;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  int m_y, m_gt, m_lt, m_ov, m_ms, m_cnt8, m_cnt2;
  bit m_sampled;

  always #5 clk = ~clk;

  compare_1b #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .y(y), .gt(gt), .lt(lt), .out_valid(out_valid),
    .match_cnt(match_cnt), .mismatch_seen(mismatch_seen)
  );

  compare_1b #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .y(y2), .gt(gt2), .lt(lt2), .out_valid(ov2),
    .match_cnt(cnt2), .mismatch_seen(ms2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_edge(bit r, bit e, bit ai, bit bi);
    if (r) begin
      {m_y, m_gt, m_lt, m_ov, m_ms, m_cnt8, m_cnt2} = '0;
      m_sampled = 0;
    end else begin
      m_ov = e;
      if (e) begin
        m_y  = (ai == bi);
        m_gt = (ai > bi);
        m_lt = (ai < bi);
        m_sampled = 1;
        if (ai == bi) begin
          m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
          m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
        end else begin
          m_ms = 1;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".y"},   y,             m_y);
    check({tag, ".gt"},  gt,            m_gt);
    check({tag, ".lt"},  lt,            m_lt);
    check({tag, ".ov"},  out_valid,     m_ov);
    check({tag, ".cnt"}, match_cnt,     m_cnt8);
    check({tag, ".ms"},  mismatch_seen, m_ms);
    check({tag, ".y2"},  y2,            m_y);
    check({tag, ".cnt2"}, cnt2,         m_cnt2);
    check({tag, ".ms2"}, ms2,           m_ms);
    check({tag, ".ov2"}, ov2,           m_ov);
    if (m_sampled)
      check({tag, ".onehot"}, y + gt + lt, 1);
  endtask

  task automatic step(input string tag, input bit r, input bit e,
                      input bit ai, input bit bi);
    @(negedge clk);
    rst = r; en = e; a = ai; b = bi;
    @(posedge clk);
    #1;
    model_edge(r, e, ai, bi);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0;
    m_sampled = 0;
    step("reset", 1, 0, 0, 0);
    check("reset.allzero", {y, gt, lt, out_valid, mismatch_seen}, 0);

    step("tt00", 0, 1, 0, 0);
    step("tt01", 0, 1, 0, 1);
    check("tt01.ms_set", mismatch_seen, 1);
    step("tt10", 0, 1, 1, 0);
    check("tt10.gt", gt, 1);
    step("tt11", 0, 1, 1, 1);
    check("tt.cnt_end", match_cnt, 2);

    for (int i = 0; i < 5; i++)
      step("idle", 0, 0, i[0], ~i[0]);
    check("idle.y_hold", y, 1);
    check("idle.cnt_hold", match_cnt, 2);

    step("rst2", 1, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step("sat", 0, 1, 0, 0);
    check("sat.cnt2", cnt2, 3);
    check("sat.ms2", ms2, 0);

    step("midrst", 1, 1, 0, 1);
    check("midrst.cnt", match_cnt, 0);
    check("midrst.ms", mismatch_seen, 0);
    step("after_rst", 0, 1, 1, 1);
    check("after_rst.cnt", match_cnt, 1);

    // rst raised between edges must not clear anything yet
    step("pre_sync", 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    #2;
    check_all("sync_hold");
    @(posedge clk);
    #1;
    model_edge(1, 0, 0, 0);
    check_all("sync_clr");

    for (int i = 0; i < 1000; i++) begin
      bit r, e, ai, bi;
      r  = ($urandom_range(0, 49) == 0);
      e  = $urandom_range(0, 3) != 0;
      ai = $urandom_range(0, 1);
      bi = $urandom_range(0, 1);
      step("rand", r, e, ai, bi);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/compare_1b.md
Name: compare_1b

Overview:
- Registered 1-bit magnitude/equality comparator.
- Primary output y asserts when inputs a and b are equal.
- Auxiliary outputs gt/lt, a valid flag, a saturating match counter and a sticky mismatch flag support result qualification and on-line checking.
- Used as a leaf comparator cell in datapath and self-check logic. One clock domain.

Parameters:
CNT_W, 8, width of match_cnt counter (>=1).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  sample enable; a/b compared only on edges where en=1.
a  input  1  operand A.
b  input  1  operand B.
y  output  1  registered equality result: 1 when a==b at last enabled sample.
gt  output  1  registered: 1 when a=1, b=0 at last enabled sample.
lt  output  1  registered: 1 when a=0, b=1 at last enabled sample.
out_valid  output  1  1 for exactly the cycle after an enabled sample.
match_cnt  output  CNT_W  count of enabled samples with a==b; saturates.
mismatch_seen  output  1  sticky; set by any enabled sample with a!=b.

Behaviour:
- Reset is synchronous and active-high. On a rising clk edge with rst=1, set y=0, gt=0, lt=0, out_valid=0, match_cnt=0, mismatch_seen=0.
- rst dominates en; inputs are ignored on reset edges.
- Reset may be asserted at any time, including mid-sequence; clearing happens on the next edge.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency is 1 clock: a sample taken at edge N is visible after edge N and stays until the next enabled edge or reset.
- Enabled edge (rst=0, en=1):
  - y <= ~(a ^ b)
  - gt <= a & ~b
  - lt <= ~a & b
  - out_valid <= 1
  - if a==b, match_cnt <= match_cnt+1, unless it already equals 2^CNT_W-1, in which case it holds (saturating, no wrap)
  - if a!=b, mismatch_seen <= 1
- Invariant: exactly one of y, gt, lt is 1 after any enabled sample. All three are 0 only after reset and before the first enabled sample.
- Idle edge (rst=0, en=0): y, gt, lt, match_cnt and mismatch_seen hold; out_valid <= 0.
- mismatch_seen clears only on reset.
- Truth table for y: (a,b)=00->1, 01->0, 10->0, 11->1.
- Inputs X/Z: not handled specially; the environment guarantees known values when en=1.

Test Plan:
- Reset, then en=1 each cycle with (a,b)=00,01,10,11 held 1 cycle each -> y=1,0,0,1; gt=0,0,1,0; lt=0,1,0,0; out_valid=1 each following cycle; match_cnt ends at 2; mismatch_seen=1 after the 01 sample.
- After an enabled sample (a,b)=11, drop en and toggle a/b for 5 cycles -> y stays 1, match_cnt unchanged, out_valid=0 from the second edge on.
- CNT_W=2 with (a,b)=00 enabled for 6 cycles -> match_cnt goes 1,2,3,3,3,3; mismatch_seen stays 0.
- Mid-sequence rst=1 for 1 cycle with en=1 and (a,b)=01 -> after that edge all outputs are 0 and mismatch_seen is 0. The next enabled (a,b)=11 gives y=1, match_cnt=1.
- rst asserted without a clock edge -> outputs unchanged until the next rising edge, confirming synchronous reset.
- Random (a,b,en) for 1000 cycles against a reference model -> y/gt/lt one-hot after the first enabled sample; all outputs match the model.
